// File: rtl/pipe_scheduler_pkg.sv
// Shared encodings for the pipe scheduler: game states, slot field layout, LFSR taps.
package pipe_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int SLOT_W  = 24;
    localparam int POS_LSB = 16;
    localparam int MAX_LSB = 8;
    localparam int MIN_LSB = 0;

    // Feedback taps on bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR; advances one step per enabled cycle, reset loads SEED.
// Latency 1 cycle; no backpressure.
module lfsr8
    import pipe_scheduler_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (en) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Scrolls and respawns pipe-gap slots, scores passes and halts on bird/pipe collision.
// Latency 1 cycle from tick to pipes/score; no backpressure, ticks outside RUN are dropped.
module pipe_scheduler
    import pipe_scheduler_pkg::*;
#(
    parameter int         N_PIPE    = 3,
    parameter int         SPACING   = 50,
    parameter int         FIRST_POS = 50,
    parameter int         RST_MIN   = 20,
    parameter int         GAP       = 10,
    parameter int         GAP_FLOOR = 8,
    parameter logic [7:0] GAP_MASK  = 8'h1F,
    parameter int         BIRD_COL  = 4,
    parameter int         HALF_W    = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     tick,
    input  logic                     restart,
    input  logic [7:0]               altitude,
    output logic [SLOT_W*N_PIPE-1:0] pipes,
    output logic [15:0]              score,
    output logic [1:0]               state,
    output logic                     collide,
    output logic                     spawn
);

    if (N_PIPE * SPACING - 1 > 255) begin : g_bad_span
        $error("pipe_scheduler: N_PIPE*SPACING-1 exceeds 8 bits");
    end
    if (GAP_FLOOR + int'(GAP_MASK) + GAP > 255) begin : g_bad_gap
        $error("pipe_scheduler: GAP_FLOOR+GAP_MASK+GAP exceeds 8 bits");
    end
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
        $error("pipe_scheduler: LFSR_SEED must be nonzero");
    end

    localparam logic [7:0] RESPAWN_POS = 8'(N_PIPE * SPACING - 1);
    localparam logic [7:0] WIN_LO      = 8'((BIRD_COL > HALF_W) ? BIRD_COL - HALF_W : 0);
    localparam logic [7:0] WIN_HI      = 8'(BIRD_COL + HALF_W);
    localparam logic [7:0] BIRD_POS    = 8'(BIRD_COL);

    state_t            st, st_nxt;
    logic [7:0]        lfsr;
    logic [7:0]        new_min, new_max;
    logic [N_PIPE-1:0] hit, resp, at_bird;
    logic              collision, adv;

    assign state     = st;
    assign collision = (st == ST_RUN) && (|hit);
    // Restart and collision both pre-empt a tick on the same edge.
    assign adv       = (st == ST_RUN) && tick && !collision && !restart;
    assign new_min   = 8'(GAP_FLOOR) + (lfsr & GAP_MASK);
    assign new_max   = new_min + 8'(GAP);

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .value (lfsr)
    );

    for (genvar g = 0; g < N_PIPE; g++) begin : g_slot
        localparam logic [7:0] INIT_POS = 8'(FIRST_POS + g * SPACING);
        logic [7:0] pos_q, max_q, min_q;

        assign hit[g]     = (pos_q >= WIN_LO) && (pos_q <= WIN_HI) &&
                            ((altitude <= min_q) || (altitude >= max_q));
        assign resp[g]    = (pos_q == 8'd0);
        assign at_bird[g] = (pos_q == BIRD_POS);

        always_ff @(posedge clk) begin
            if (rst || restart) begin
                pos_q <= INIT_POS;
                min_q <= 8'(RST_MIN);
                max_q <= 8'(RST_MIN + GAP);
            end else if (adv) begin
                if (resp[g]) begin
                    pos_q <= RESPAWN_POS;
                    min_q <= new_min;
                    max_q <= new_max;
                end else begin
                    pos_q <= pos_q - 8'd1;
                end
            end
        end

        assign pipes[SLOT_W*g+POS_LSB +: 8] = pos_q;
        assign pipes[SLOT_W*g+MAX_LSB +: 8] = max_q;
        assign pipes[SLOT_W*g+MIN_LSB +: 8] = min_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        if (restart) begin
            st_nxt = ST_IDLE;
        end else begin
            case (st)
                ST_IDLE: if (start) st_nxt = ST_RUN;
                ST_RUN:  if (collision) st_nxt = ST_HALT;
                ST_HALT: st_nxt = ST_HALT;
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            score   <= 16'd0;
            collide <= 1'b0;
            spawn   <= 1'b0;
        end else begin
            spawn <= adv && (|resp);
            if (collision) begin
                collide <= 1'b1;
            end
            if (adv && (|at_bird) && (score != 16'hFFFF)) begin
                score <= score + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Scoreboard bench for pipe_scheduler: stimulus queues expected outputs per cycle, a monitor compares them.
module tb_pipe_scheduler;
    import pipe_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, tick, restart;
    logic [7:0]  altitude;
    logic [71:0] pipes;
    logic [15:0] score;
    logic [1:0]  state;
    logic        collide, spawn;

    pipe_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tick     (tick),
        .restart  (restart),
        .altitude (altitude),
        .pipes    (pipes),
        .score    (score),
        .state    (state),
        .collide  (collide),
        .spawn    (spawn)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [71:0] pipes;
        logic [15:0] score;
        logic [1:0]  state;
        logic        collide;
        logic        spawn;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [7:0] lf = 8'hA5;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lstep(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic chk(input string nm, input string fld, input logic [71:0] got, input logic [71:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s.%s got %h want %h (cycle %0d)", nm, fld, got, want, cyc);
    endtask

    // Slots 1 and 2 keep their reset bounds in every scenario checked here.
    task automatic expect_out(input string nm, input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] mn0, input logic [15:0] sc,
                              input logic [1:0] st, input logic col, input logic spn);
        exp_t e;
        e.cyc     = cyc + 1;
        e.name    = nm;
        e.pipes   = {p2, 8'd30, 8'd20, p1, 8'd30, 8'd20, p0, mn0 + 8'd10, mn0};
        e.score   = sc;
        e.state   = st;
        e.collide = col;
        e.spawn   = spn;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "pipes",   72'(pipes),   72'(e.pipes));
            chk(e.name, "score",   72'(score),   72'(e.score));
            chk(e.name, "state",   72'(state),   72'(e.state));
            chk(e.name, "collide", 72'(collide), 72'(e.collide));
            chk(e.name, "spawn",   72'(spawn),   72'(e.spawn));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic run_to_respawn(input string tag);
        logic [7:0] mn;
        for (int k = 1; k <= 50; k++) begin
            tick = 1'b1;
            expect_out({tag, "_scroll"}, 8'(50 - k), 8'(100 - k), 8'(150 - k), 8'd20,
                       (k >= 47) ? 16'd1 : 16'd0, 2'd1, 1'b0, 1'b0);
            lf = lstep(lf);
            step();
        end
        mn = 8'd8 + (lf & 8'h1F);
        expect_out({tag, "_respawn"}, 8'd149, 8'd49, 8'd99, mn, 16'd1, 2'd1, 1'b0, 1'b1);
        lf = lstep(lf);
        step();
        tick = 1'b0;
        expect_out({tag, "_spawn_clr"}, 8'd149, 8'd49, 8'd99, mn, 16'd1, 2'd1, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tick = 1'b1; restart = 1'b0; altitude = 8'd25;
        #1;
        expect_out("reset", 8'd50, 8'd100, 8'd150, 8'd20, 16'd0, 2'd0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_out("idle_tick", 8'd50, 8'd100, 8'd150, 8'd20, 16'd0, 2'd0, 1'b0, 1'b0);
            step();
        end

        tick = 1'b0; start = 1'b1;
        expect_out("start1", 8'd50, 8'd100, 8'd150, 8'd20, 16'd0, 2'd1, 1'b0, 1'b0);
        step();
        start = 1'b0;
        run_to_respawn("run1");

        restart = 1'b1;
        expect_out("restart1", 8'd50, 8'd100, 8'd150, 8'd20, 16'd0, 2'd0, 1'b0, 1'b0);
        step();
        restart = 1'b0; start = 1'b1; altitude = 8'd15;
        expect_out("start2", 8'd50, 8'd100, 8'd150, 8'd20, 16'd0, 2'd1, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            tick = 1'b1;
            expect_out("approach", 8'(50 - k), 8'(100 - k), 8'(150 - k), 8'd20,
                       16'd0, 2'd1, 1'b0, 1'b0);
            lf = lstep(lf);
            step();
        end
        expect_out("collide_tick", 8'd6, 8'd56, 8'd106, 8'd20, 16'd0, 2'd2, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            expect_out("halt_hold", 8'd6, 8'd56, 8'd106, 8'd20, 16'd0, 2'd2, 1'b1, 1'b0);
            step();
        end

        tick = 1'b0; restart = 1'b1; altitude = 8'd25;
        expect_out("restart2", 8'd50, 8'd100, 8'd150, 8'd20, 16'd0, 2'd0, 1'b0, 1'b0);
        step();
        restart = 1'b0; start = 1'b1;
        expect_out("start3", 8'd50, 8'd100, 8'd150, 8'd20, 16'd0, 2'd1, 1'b0, 1'b0);
        step();
        start = 1'b0;
        run_to_respawn("run3");

        repeat (3) step();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            $display("FAIL %s never compared got none want cycle %0d", e.name, e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
